// File: rtl/bus_cycle_sequencer.sv
// bus_cycle_sequencer
// Sequences the 8-phase instruction cycle A1 A2 A3 M1 M2 X1 X2 X3. A
// two-word instruction gets a second fetch cycle before it executes. The
// run request starts and stops the sequencer only at instruction boundaries.
//
// state | meaning
// IDLE  | stopped; resume counter runs while i_run=1
// A1-A3 | PC nibble low/mid/high driven on bus, PC increments in A3
// M1-M2 | opcode (first word) or operand (second word) nibbles latched
// X1-X3 | execute window; dead phases in a first word with a second pending
//
// Ports:
//   i_clk, i_rst          clock, synchronous active-high reset
//   i_run                 1 = run continuously, 0 = stop at next boundary
//   i_two_word            decoder flag, sampled at M2 of a first word
//   i_jump_taken          branch flag, sampled at X3 of an execute cycle
//   o_phase               one-hot phase (bit0=A1 .. bit7=X3), 0 in IDLE
//   o_sync                one clock before every A1
//   o_addr_sel, o_bus_oe  PC nibble select and bus drive during A1-A3
//   o_ir_*_load           opcode latches (first word)
//   o_op_*_load           operand latches (second word)
//   o_exec_en             execute window of the final word
//   o_pc_inc, o_pc_load   PC control pulses
//   o_second_word, o_busy cycle status
module bus_cycle_sequencer #(
    parameter int unsigned RESUME_DELAY = 0
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_run,
    input  logic       i_two_word,
    input  logic       i_jump_taken,
    output logic [7:0] o_phase,
    output logic       o_sync,
    output logic [1:0] o_addr_sel,
    output logic       o_bus_oe,
    output logic       o_ir_hi_load,
    output logic       o_ir_lo_load,
    output logic       o_op_hi_load,
    output logic       o_op_lo_load,
    output logic       o_exec_en,
    output logic       o_pc_inc,
    output logic       o_pc_load,
    output logic       o_second_word,
    output logic       o_busy
);

    localparam logic [2:0] LP_DELAY = 3'(RESUME_DELAY);

    typedef enum logic [3:0] {
        S_IDLE, S_A1, S_A2, S_A3, S_M1, S_M2, S_X1, S_X2, S_X3
    } state_t;

    state_t     r_state, w_next_state;
    logic       r_word, w_next_word;
    logic       r_tw_latched, w_next_tw_latched;
    logic [2:0] r_cnt, w_next_cnt;
    logic       w_final;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= S_IDLE;
            r_word       <= 1'b0;
            r_tw_latched <= 1'b0;
            r_cnt        <= 3'd0;
        end else begin
            r_state      <= w_next_state;
            r_word       <= w_next_word;
            r_tw_latched <= w_next_tw_latched;
            r_cnt        <= w_next_cnt;
        end
    end

    // A cycle executes unless it is a first word with a second word pending.
    assign w_final = r_word | ~r_tw_latched;

    always_comb begin
        w_next_state      = r_state;
        w_next_word       = r_word;
        w_next_tw_latched = r_tw_latched;
        w_next_cnt        = r_cnt;
        o_phase           = 8'h00;
        o_sync            = 1'b0;
        o_addr_sel        = 2'd0;
        o_bus_oe          = 1'b0;
        o_ir_hi_load      = 1'b0;
        o_ir_lo_load      = 1'b0;
        o_op_hi_load      = 1'b0;
        o_op_lo_load      = 1'b0;
        o_exec_en         = 1'b0;
        o_pc_inc          = 1'b0;
        o_pc_load         = 1'b0;
        o_second_word     = 1'b0;
        o_busy            = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (i_run) begin
                    if (r_cnt == LP_DELAY) begin
                        w_next_state = S_A1;
                        w_next_word  = 1'b0;
                        w_next_cnt   = 3'd0;
                        o_sync       = 1'b1;
                    end else begin
                        w_next_cnt = r_cnt + 3'd1;
                    end
                end else begin
                    w_next_cnt = 3'd0;
                end
            end
            S_A1: begin
                w_next_state = S_A2;
                o_phase      = 8'h01;
                o_bus_oe     = 1'b1;
                o_addr_sel   = 2'd0;
            end
            S_A2: begin
                w_next_state = S_A3;
                o_phase      = 8'h02;
                o_bus_oe     = 1'b1;
                o_addr_sel   = 2'd1;
            end
            S_A3: begin
                w_next_state = S_M1;
                o_phase      = 8'h04;
                o_bus_oe     = 1'b1;
                o_addr_sel   = 2'd2;
                o_pc_inc     = 1'b1;
            end
            S_M1: begin
                w_next_state = S_M2;
                o_phase      = 8'h08;
                o_ir_hi_load = ~r_word;
                o_op_hi_load = r_word;
            end
            S_M2: begin
                w_next_state = S_X1;
                o_phase      = 8'h10;
                o_ir_lo_load = ~r_word;
                o_op_lo_load = r_word;
                // A second word never requests a third.
                if (!r_word) begin
                    w_next_tw_latched = i_two_word;
                end
            end
            S_X1: begin
                w_next_state = S_X2;
                o_phase      = 8'h20;
                o_exec_en    = w_final;
            end
            S_X2: begin
                w_next_state = S_X3;
                o_phase      = 8'h40;
                o_exec_en    = w_final;
            end
            S_X3: begin
                o_phase           = 8'h80;
                o_exec_en         = w_final;
                o_pc_load         = w_final & i_jump_taken;
                o_sync            = 1'b1;
                w_next_tw_latched = 1'b0;
                // A pending second word overrides a stop request.
                if (!r_word && r_tw_latched) begin
                    w_next_state = S_A1;
                    w_next_word  = 1'b1;
                end else if (i_run) begin
                    w_next_state = S_A1;
                    w_next_word  = 1'b0;
                end else begin
                    w_next_state = S_IDLE;
                    w_next_word  = 1'b0;
                end
            end
            default: begin
                w_next_state = S_IDLE;
                w_next_word  = 1'b0;
            end
        endcase

        if (r_state != S_IDLE) begin
            o_busy        = 1'b1;
            o_second_word = r_word;
        end
    end

endmodule

// File: tb/tb_bus_cycle_sequencer.sv
module tb_bus_cycle_sequencer;

    logic clk = 1'b0;
    logic rst, run, two_word, jump_taken;

    logic [7:0] phase0, phase3;
    logic       sync0, sync3, bus_oe0, bus_oe3;
    logic [1:0] addr_sel0, addr_sel3;
    logic       irh0, irl0, oph0, opl0, ex0, inc0, ld0, sec0, busy0;
    logic       irh3, irl3, oph3, opl3, ex3, inc3, ld3, sec3, busy3;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    bus_cycle_sequencer #(.RESUME_DELAY(0)) dut0 (
        .i_clk(clk), .i_rst(rst), .i_run(run), .i_two_word(two_word),
        .i_jump_taken(jump_taken), .o_phase(phase0), .o_sync(sync0),
        .o_addr_sel(addr_sel0), .o_bus_oe(bus_oe0), .o_ir_hi_load(irh0),
        .o_ir_lo_load(irl0), .o_op_hi_load(oph0), .o_op_lo_load(opl0),
        .o_exec_en(ex0), .o_pc_inc(inc0), .o_pc_load(ld0),
        .o_second_word(sec0), .o_busy(busy0)
    );

    bus_cycle_sequencer #(.RESUME_DELAY(3)) dut3 (
        .i_clk(clk), .i_rst(rst), .i_run(run), .i_two_word(two_word),
        .i_jump_taken(jump_taken), .o_phase(phase3), .o_sync(sync3),
        .o_addr_sel(addr_sel3), .o_bus_oe(bus_oe3), .o_ir_hi_load(irh3),
        .o_ir_lo_load(irl3), .o_op_hi_load(oph3), .o_op_lo_load(opl3),
        .o_exec_en(ex3), .o_pc_inc(inc3), .o_pc_load(ld3),
        .o_second_word(sec3), .o_busy(busy3)
    );

    // ph: -1 = IDLE, 0..7 = A1..X3; fin = cycle executes; syn = IDLE about to start
    typedef struct {
        logic rst, run, tw, jt;
        int   ph;
        logic word, fin, syn;
    } vec_t;

    vec_t          vecs[$];
    logic [20:0]   sb[$];

    // Expected output word {phase, sync, addrSel, busOe, irHi, irLo, opHi,
    // opLo, execEn, pcInc, pcLoad, secondWord, busy} derived from the phase table.
    function automatic logic [20:0] mk(int ph, logic word, logic fin, logic syn, logic jt);
        logic [7:0] p;
        logic [1:0] a;
        p = 8'h00;
        if (ph >= 0) p[ph] = 1'b1;
        a = (ph == 1) ? 2'd1 : (ph == 2) ? 2'd2 : 2'd0;
        return {p, (ph == 7) || syn, a, (ph >= 0 && ph <= 2),
                (ph == 3 && !word), (ph == 4 && !word),
                (ph == 3 && word), (ph == 4 && word),
                (ph >= 5 && fin), (ph == 2), (ph == 7 && fin && jt),
                (ph >= 0 && word), (ph >= 0)};
    endfunction

    function automatic logic [20:0] act0();
        return {phase0, sync0, addr_sel0, bus_oe0, irh0, irl0, oph0, opl0,
                ex0, inc0, ld0, sec0, busy0};
    endfunction

    function automatic logic [20:0] act3();
        return {phase3, sync3, addr_sel3, bus_oe3, irh3, irl3, oph3, opl3,
                ex3, inc3, ld3, sec3, busy3};
    endfunction

    task automatic add(logic r, logic rn, logic tw, logic jt, int ph,
                       logic w, logic f, logic s);
        vec_t v;
        v.rst = r; v.run = rn; v.tw = tw; v.jt = jt;
        v.ph = ph; v.word = w; v.fin = f; v.syn = s;
        vecs.push_back(v);
    endtask

    task automatic add_cycle(logic rn, logic tw, logic jt, logic w, logic f);
        for (int i = 0; i < 8; i++) add(1'b0, rn, tw, jt, i, w, f, 1'b0);
    endtask

    task automatic drive(logic r, logic rn, logic tw, logic jt);
        @(negedge clk);
        rst = r; run = rn; two_word = tw; jump_taken = jt;
    endtask

    task automatic compare(string name, int idx, logic [20:0] act);
        logic [20:0] exp;
        exp = sb.pop_front();
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d got %h want %h", name, idx, act, exp);
        end
    endtask

    int pc_inc_count;

    initial begin
        rst = 1'b1; run = 1'b0; two_word = 1'b0; jump_taken = 1'b0;

        add(0, 0, 0, 0, -1, 0, 0, 0);          // reset state
        add(0, 1, 0, 0, -1, 0, 0, 1);          // run rises: sync before A1
        add_cycle(1, 0, 0, 0, 1);              // three back-to-back single words
        add_cycle(1, 0, 0, 0, 1);
        add_cycle(1, 0, 0, 0, 1);
        add_cycle(0, 1, 1, 0, 0);              // two-word, run dropped, dead X3 with jump
        add_cycle(0, 1, 1, 1, 1);              // second word, twoWord ignored, jump at X3
        add(0, 0, 0, 0, -1, 0, 0, 0);          // stopped
        add(0, 1, 0, 0, -1, 0, 0, 1);
        add_cycle(1, 0, 1, 0, 1);              // jump held across execute cycle
        add_cycle(1, 1, 0, 0, 0);              // first word of a two-word
        for (int i = 0; i < 3; i++) add(0, 1, 0, 0, i, 1, 1, 0);
        add(1, 1, 0, 0, 3, 1, 1, 0);           // reset at M1 of second word
        add(0, 0, 0, 0, -1, 0, 0, 0);          // everything cleared
        add(0, 1, 0, 0, -1, 0, 0, 1);
        for (int i = 0; i < 5; i++) add(0, 1, 0, 0, i, 0, 1, 0);  // restarts as first word

        drive(1, 0, 0, 0);
        drive(1, 0, 0, 0);

        pc_inc_count = 0;
        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].run, vecs[i].tw, vecs[i].jt);
            sb.push_back(mk(vecs[i].ph, vecs[i].word, vecs[i].fin,
                            vecs[i].syn, vecs[i].jt));
            #1;
            if (i >= 2 && i < 26 && inc0) pc_inc_count++;
            compare("vec", i, act0());
        end

        checks++;
        if (pc_inc_count != 3) begin
            errors++;
            $display("FAIL pcinc_count got %0d want 3", pc_inc_count);
        end

        // RESUME_DELAY=3 instance: run toggle restarts the count, then 4 clocks to A1.
        begin
            logic run_seq [9] = '{1, 1, 0, 1, 1, 1, 1, 1, 1};
            int   ph_seq  [9] = '{-1, -1, -1, -1, -1, -1, -1, 0, 1};
            logic syn_seq [9] = '{0, 0, 0, 0, 0, 0, 1, 0, 0};
            drive(1, 0, 0, 0);
            for (int i = 0; i < 9; i++) begin
                drive(0, run_seq[i], 0, 0);
                sb.push_back(mk(ph_seq[i], 1'b0, 1'b1, syn_seq[i], 1'b0));
                #1;
                compare("resume", i, act3());
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
